// File: rtl/mux_rr_arbiter_if.sv
// Request/data bus between four requesters and the round-robin channel arbiter.
// The requester side is the master; the arbiter is the slave.
interface mux_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] data;
  logic [3:0] grant;
  logic [1:0] select;
  logic       valid;
  logic       result;

  modport master (
    output req,
    output data,
    input  grant,
    input  select,
    input  valid,
    input  result
  );

  modport slave (
    input  req,
    input  data,
    output grant,
    output select,
    output valid,
    output result
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 4:1 one-bit channel with a bounded hold window.
// Drives the channel select and registers the selected bit with a valid flag.
//
// state  | meaning
// IDLE   | no owner; grant is zero, select keeps the previous owner
// BUSY   | select owns the channel; r_cnt counts owned cycles (1..HOLD_MAX)
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  mux_rr_arbiter_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold_max
    $error("mux_rr_arbiter: HOLD_MAX must be within 1..15");
  end

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_last;
  logic [3:0] r_grant;
  logic [1:0] r_select;
  logic       r_valid;
  logic       r_result;

  logic       w_any_req;
  logic       w_owner_req;
  logic       w_expire;
  logic [1:0] w_pick_last;
  logic [1:0] w_pick_owner;

  // Search r+1, r+2, r+3, then r itself; r only wins when nobody else asks.
  function automatic logic [1:0] rr_pick(input logic [3:0] rq, input logic [1:0] r);
    logic [1:0] idx;
    logic       found;
    rr_pick = r;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = r + 2'(k);
      if (!found && rq[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  assign w_any_req    = |bus.req;
  assign w_owner_req  = bus.req[r_select];
  assign w_expire     = (r_cnt == HOLD_LIM);
  assign w_pick_last  = rr_pick(bus.req, r_last);
  assign w_pick_owner = rr_pick(bus.req, r_select);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_last   <= 2'b11;
      r_grant  <= 4'b0000;
      r_select <= 2'b00;
      r_valid  <= 1'b0;
      r_result <= 1'b0;
    end else begin
      r_valid  <= (r_state == S_BUSY);
      r_result <= (r_state == S_BUSY) ? bus.data[r_select] : 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state  <= S_BUSY;
            r_grant  <= onehot(w_pick_last);
            r_select <= w_pick_last;
            r_cnt    <= 4'd1;
          end else begin
            r_grant <= 4'b0000;
          end
        end

        S_BUSY: begin
          if (w_owner_req && !w_expire) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            // Release or expire: hand off with no idle gap if anyone is waiting.
            r_last <= r_select;
            if (w_any_req) begin
              r_grant  <= onehot(w_pick_owner);
              r_select <= w_pick_owner;
              r_cnt    <= 4'd1;
            end else begin
              r_state <= S_IDLE;
              r_grant <= 4'b0000;
              r_cnt   <= 4'd0;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_grant <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.grant  = r_grant;
  assign bus.select = r_select;
  assign bus.valid  = r_valid;
  assign bus.result = r_result;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed request/data vectors, an owner/queue-style
// reference model checked every cycle, and literal grant expectations.
module tb_mux_rr_arbiter;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic reset;
  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the channel, for how long, and who went last.
  int         m_owner;
  int         m_held;
  int         m_ptr;
  logic [1:0] m_sel;
  logic       m_valid;
  logic       m_result;
  bit         m_ready = 1'b0;

  function automatic int next_owner(input logic [3:0] rq, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (rq[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_owner  = -1;
      m_held   = 0;
      m_ptr    = 3;
      m_sel    = 2'b00;
      m_valid  = 1'b0;
      m_result = 1'b0;
      m_ready  = 1'b1;
    end else if (m_ready) begin
      m_valid  = (m_owner >= 0);
      m_result = (m_owner >= 0) ? bus.data[m_owner] : 1'b0;
      if (m_owner < 0) begin
        m_owner = next_owner(bus.req, m_ptr);
        if (m_owner >= 0) begin
          m_held = 1;
          m_sel  = 2'(m_owner);
        end
      end else if (bus.req[m_owner] && m_held < HOLD) begin
        m_held = m_held + 1;
      end else begin
        m_ptr   = m_owner;
        m_owner = next_owner(bus.req, m_owner);
        m_held  = (m_owner >= 0) ? 1 : 0;
        if (m_owner >= 0) m_sel = 2'(m_owner);
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] eg;
    if (m_ready) begin
      eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      total++;
      if (bus.grant !== eg) begin
        bad++;
        $display("FAIL model_grant t=%0t got=%b want=%b", $time, bus.grant, eg);
      end
      total++;
      if (bus.select !== m_sel) begin
        bad++;
        $display("FAIL model_select t=%0t got=%0d want=%0d", $time, bus.select, m_sel);
      end
      total++;
      if (bus.valid !== m_valid) begin
        bad++;
        $display("FAIL model_valid t=%0t got=%b want=%b", $time, bus.valid, m_valid);
      end
      total++;
      if (bus.result !== m_result) begin
        bad++;
        $display("FAIL model_result t=%0t got=%b want=%b", $time, bus.result, m_result);
      end
      total++;
      if ($countones(bus.grant) > 1) begin
        bad++;
        $display("FAIL grant_onehot t=%0t got=%b want=at most one bit", $time, bus.grant);
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", nm, $time, got, exp);
    end
  endtask

  task automatic tick(input logic [3:0] rq, input logic [3:0] dt, input logic rs);
    reset    = rs;
    bus.req  = rq;
    bus.data = dt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    bus.req  = 4'b1111;
    bus.data = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant",  bus.grant, 4'b0000);
    chk("reset_select", {2'b00, bus.select}, 4'd0);
    chk("reset_valid",  {3'b000, bus.valid}, 4'd0);
    chk("reset_result", {3'b000, bus.result}, 4'd0);

    // Full contention: four-cycle slots rotating 0,1,2,3,0...
    for (int i = 0; i < 17; i++) begin
      tick(4'b1111, (i % 2 == 1) ? 4'b1010 : 4'b0101, 1'b0);
      chk("contention_grant", bus.grant, 4'b0001 << ((i / 4) % 4));
    end

    tick(4'b0000, 4'b0000, 1'b1);

    // Single requester re-granted on expiry with no gap.
    for (int k = 1; k <= 10; k++) begin
      tick(4'b0100, 4'b0100, 1'b0);
      chk("single_grant",  bus.grant, 4'b0100);
      chk("single_select", {2'b00, bus.select}, 4'd2);
      if (k >= 2) begin
        chk("single_valid",  {3'b000, bus.valid},  4'd1);
        chk("single_result", {3'b000, bus.result}, 4'd1);
      end
    end
    tick(4'b0000, 4'b0000, 1'b0);
    chk("single_release", bus.grant, 4'b0000);

    // Early release of owner 1 to waiting requester 3, then drop to idle.
    tick(4'b0010, 4'b0010, 1'b0);
    chk("early_g1", bus.grant, 4'b0010);
    tick(4'b1010, 4'b1010, 1'b0);
    chk("early_g2", bus.grant, 4'b0010);
    tick(4'b1000, 4'b1000, 1'b0);
    chk("early_g3", bus.grant, 4'b1000);
    tick(4'b0000, 4'b0000, 1'b0);
    chk("idle_grant",   bus.grant, 4'b0000);
    chk("idle_valid1",  {3'b000, bus.valid}, 4'd1);
    chk("idle_select1", {2'b00, bus.select}, 4'd3);
    tick(4'b0000, 4'b0000, 1'b0);
    chk("idle_valid2",  {3'b000, bus.valid}, 4'd0);
    chk("idle_select2", {2'b00, bus.select}, 4'd3);

    // Fairness pointer: after 3, requester 0 first, then 3 after 0 expires.
    for (int k = 0; k < 4; k++) begin
      tick(4'b1001, 4'b0001, 1'b0);
      chk("fair_first", bus.grant, 4'b0001);
    end
    tick(4'b1001, 4'b1000, 1'b0);
    chk("fair_next", bus.grant, 4'b1000);

    // Reset in the middle of an ownership window.
    tick(4'b0000, 4'b0000, 1'b0);
    tick(4'b0100, 4'b0100, 1'b0);
    tick(4'b0100, 4'b0100, 1'b0);
    chk("mid_pre", bus.grant, 4'b0100);
    tick(4'b0100, 4'b0100, 1'b1);
    chk("mid_rst_grant",  bus.grant, 4'b0000);
    chk("mid_rst_select", {2'b00, bus.select}, 4'd0);
    chk("mid_rst_valid",  {3'b000, bus.valid}, 4'd0);
    chk("mid_rst_result", {3'b000, bus.result}, 4'd0);
    tick(4'b0100, 4'b0100, 1'b0);
    chk("mid_regrant", bus.grant, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      tick(4'b0101, 4'b0001, 1'b0);
      chk("mid_window", bus.grant, 4'b0100);
    end
    tick(4'b0101, 4'b0001, 1'b0);
    chk("mid_expire", bus.grant, 4'b0001);

    tick(4'b0000, 4'b0000, 1'b0);
    tick(4'b0000, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
